// File: rtl/q_change_fifo.sv
// Watches the upstream 2-bit q register and queues every new value it takes.
// Queued values leave over a valid/ready port; a sticky flag records any value lost while the FIFO was full.
module q_change_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           q_in,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [WIDTH-1:0] prev_reg;
   logic             prev_valid_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             overflow_reg;

   logic             change;
   logic             full;
   logic             pop;
   logic             push_ok;
   logic             drop;
   logic [DEPTH-1:0] wr_en;

   assign change  = prev_valid_reg && (q_in != prev_reg);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign pop     = out_valid && out_ready;
   // When full, a simultaneous pop frees the slot the new entry lands in.
   assign push_ok = change && (!full || pop);
   assign drop    = change && full && !pop;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_reg       <= '0;
         prev_valid_reg <= 1'b0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         overflow_reg   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         prev_reg       <= q_in;
         prev_valid_reg <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
               mem_reg[i] <= q_in;
            end
         end
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (push_ok && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (!push_ok && pop) begin
            count_reg <= count_reg - 1'b1;
         end
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign out_valid = (count_reg != '0);
   assign out_data  = mem_reg[rd_ptr_reg];
   assign count     = count_reg;
   assign overflow  = overflow_reg;

endmodule
